// File: rtl/ddr_axi_pkg.sv
// AXI4 constants shared by the DDR read and write masters.
// Both directions must present identical ID/cache/size attributes to the controller.
package ddr_axi_pkg;

   localparam logic [3:0] AXI_ID         = 4'b1111;
   localparam logic [2:0] AXI_SIZE       = 3'b011;   // 8 bytes per beat
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic       AXI_LOCK       = 1'b0;
   localparam logic [3:0] AXI_CACHE      = 4'b0011;
   localparam logic [2:0] AXI_PROT       = 3'b000;
   localparam logic [3:0] AXI_QOS        = 4'b0000;

endpackage

// File: rtl/ddr_axi_write.sv
// AXI4 write master: one INCR burst per UI request, data pulled from a FWFT FIFO.
// Single outstanding burst; AW and B signals registered, W path combinational.
module ddr_axi_write
   import ddr_axi_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 29,
   parameter int BURST_LEN_WIDTH = 8
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,

   input  logic                       wr_start,
   input  logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
   input  logic [ADDR_WIDTH-1:0]      wr_start_addr,
   output logic                       wr_ready,

   input  logic [DATA_WIDTH-1:0]      wr_fifo_data,
   input  logic                       wr_fifo_empty,
   output logic                       wr_fifo_re,

   output logic                       wr_done,
   output logic [1:0]                 wr_resp,

   output logic [3:0]                 m_axi_awid,
   output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
   output logic [BURST_LEN_WIDTH-1:0] m_axi_awlen,
   output logic [2:0]                 m_axi_awsize,
   output logic [1:0]                 m_axi_awburst,
   output logic                       m_axi_awlock,
   output logic [3:0]                 m_axi_awcache,
   output logic [2:0]                 m_axi_awprot,
   output logic [3:0]                 m_axi_awqos,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,

   output logic [DATA_WIDTH-1:0]      m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]    m_axi_wstrb,
   output logic                       m_axi_wlast,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,

   input  logic [3:0]                 m_axi_bid,
   input  logic [1:0]                 m_axi_bresp,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_DONE
   } state_t;

   state_t                     state_q,   state_d;
   logic [ADDR_WIDTH-1:0]      awaddr_q,  awaddr_d;
   logic [BURST_LEN_WIDTH-1:0] awlen_q,   awlen_d;
   logic [BURST_LEN_WIDTH-1:0] cnt_q,     cnt_d;
   logic                       awvalid_q, awvalid_d;
   logic                       bready_q,  bready_d;
   logic [1:0]                 resp_q,    resp_d;

   // Responses are accepted regardless of ID: only one burst is ever in flight.
   logic unused_bid;
   assign unused_bid = ^m_axi_bid;

   // NOTE: the register process uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= S_IDLE;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         cnt_q     <= '0;
         awvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         resp_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         cnt_q     <= cnt_d;
         awvalid_q <= awvalid_d;
         bready_q  <= bready_d;
         resp_q    <= resp_d;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      awaddr_d     = awaddr_q;
      awlen_d      = awlen_q;
      cnt_d        = cnt_q;
      awvalid_d    = awvalid_q;
      bready_d     = bready_q;
      resp_d       = resp_q;
      m_axi_wvalid = 1'b0;
      m_axi_wlast  = 1'b0;
      wr_fifo_re   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (wr_start) begin
               awaddr_d  = wr_start_addr;
               // A length of zero wraps to 255, i.e. a 256-beat burst.
               awlen_d   = wr_burst_len - BURST_LEN_WIDTH'(1);
               awvalid_d = 1'b1;
               cnt_d     = '0;
               state_d   = S_AW;
            end
         end
         S_AW: begin
            if (m_axi_awready) begin
               awvalid_d = 1'b0;
               state_d   = S_W;
            end
         end
         S_W: begin
            m_axi_wvalid = !wr_fifo_empty;
            m_axi_wlast  = (cnt_q == awlen_q);
            wr_fifo_re   = m_axi_wvalid && m_axi_wready;
            if (wr_fifo_re) begin
               if (m_axi_wlast) begin
                  bready_d = 1'b1;
                  state_d  = S_B;
               end else begin
                  cnt_d = cnt_q + BURST_LEN_WIDTH'(1);
               end
            end
         end
         S_B: begin
            if (m_axi_bvalid) begin
               resp_d   = m_axi_bresp;
               bready_d = 1'b0;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign wr_ready      = (state_q == S_IDLE);
   assign wr_done       = (state_q == S_DONE);
   assign wr_resp       = resp_q;

   assign m_axi_awid    = AXI_ID;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = awlen_q;
   assign m_axi_awsize  = AXI_SIZE;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = AXI_LOCK;
   assign m_axi_awcache = AXI_CACHE;
   assign m_axi_awprot  = AXI_PROT;
   assign m_axi_awqos   = AXI_QOS;
   assign m_axi_awvalid = awvalid_q;

   assign m_axi_wdata   = wr_fifo_data;
   assign m_axi_wstrb   = '1;
   assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_ddr_axi_write.sv
// Bench for ddr_axi_write: table of burst scenarios against a FIFO/slave model and a data scoreboard,
// plus a hand-written mid-burst reset sequence.
module tb_ddr_axi_write;

   localparam int DW = 64;
   localparam int AW = 29;
   localparam int LW = 8;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          wr_start;
   logic [LW-1:0] wr_burst_len;
   logic [AW-1:0] wr_start_addr;
   logic          wr_ready;
   logic [DW-1:0] wr_fifo_data;
   logic          wr_fifo_empty;
   logic          wr_fifo_re;
   logic          wr_done;
   logic [1:0]    wr_resp;
   logic [3:0]    m_axi_awid;
   logic [AW-1:0] m_axi_awaddr;
   logic [LW-1:0] m_axi_awlen;
   logic [2:0]    m_axi_awsize;
   logic [1:0]    m_axi_awburst;
   logic          m_axi_awlock;
   logic [3:0]    m_axi_awcache;
   logic [2:0]    m_axi_awprot;
   logic [3:0]    m_axi_awqos;
   logic          m_axi_awvalid;
   logic          m_axi_awready;
   logic [DW-1:0] m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic          m_axi_wlast;
   logic          m_axi_wvalid;
   logic          m_axi_wready;
   logic [3:0]    m_axi_bid;
   logic [1:0]    m_axi_bresp;
   logic          m_axi_bvalid;
   logic          m_axi_bready;

   ddr_axi_write #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .wr_start(wr_start), .wr_burst_len(wr_burst_len), .wr_start_addr(wr_start_addr),
      .wr_ready(wr_ready),
      .wr_fifo_data(wr_fifo_data), .wr_fifo_empty(wr_fifo_empty), .wr_fifo_re(wr_fifo_re),
      .wr_done(wr_done), .wr_resp(wr_resp),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [LW-1:0] len;
      logic [AW-1:0] addr;
      int            aw_delay;
      int            gap_after;   // FIFO runs dry after this many accepted beats (0 = never)
      int            gap_len;
      int            b_delay;
      logic [1:0]    bresp;
      bit            stray_start; // pulse wr_start while waiting for awready
      logic [LW-1:0] exp_awlen;
      int            exp_beats;
   } vec_t;

   vec_t        vecs[6];
   logic [63:0] fifo_q[$];
   logic [63:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_awvalid"}, m_axi_awvalid, 0);
      check({tag, "_awaddr"},  m_axi_awaddr,  0);
      check({tag, "_awlen"},   m_axi_awlen,   0);
      check({tag, "_wvalid"},  m_axi_wvalid,  0);
      check({tag, "_wlast"},   m_axi_wlast,   0);
      check({tag, "_fifo_re"}, wr_fifo_re,    0);
      check({tag, "_bready"},  m_axi_bready,  0);
      check({tag, "_wr_done"}, wr_done,       0);
      check({tag, "_wr_resp"}, wr_resp,       0);
      check({tag, "_wr_ready"}, wr_ready,     1);
   endtask

   task automatic run_burst(input vec_t v, input int abort_after);
      int   aw_seen = 0, b_seen = 0, beat_idx = 0, gap_cnt = 0, done_cnt = 0, ready_cyc = -1;
      int   err_addr = 0, err_len = 0, err_early = 0, err_data = 0, err_last = 0;
      int   err_re = 0, err_gap = 0, err_resp = 0;
      bit   aw_hs = 0, b_hs = 0, finished = 0, aw_first = 0;
      logic [63:0] w;

      for (int i = 0; i < v.exp_beats; i++) begin
         w = {$urandom, $urandom};
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end

      @(negedge ACLK);
      check("ready_before_start", wr_ready, 1);
      wr_start      = 1'b1;
      wr_burst_len  = v.len;
      wr_start_addr = v.addr;

      for (int cyc = 1; cyc <= 2000 && !finished; cyc++) begin
         @(negedge ACLK);
         if (v.stray_start && aw_seen > 0 && !aw_hs) begin
            wr_start      = 1'b1;
            wr_start_addr = ~v.addr;
            wr_burst_len  = v.len + 8'd5;
         end else begin
            wr_start = 1'b0;
         end
         m_axi_awready = (aw_seen >= v.aw_delay) && !aw_hs;
         wr_fifo_empty = (fifo_q.size() == 0) || (gap_cnt > 0);
         wr_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
         m_axi_wready  = 1'b1;
         m_axi_bvalid  = (beat_idx == v.exp_beats) && (b_seen >= v.b_delay) && !b_hs;
         m_axi_bresp   = v.bresp;
         #1;
         if (cyc == 1) aw_first = m_axi_awvalid;
         if (m_axi_awvalid) begin
            if (m_axi_awaddr != v.addr)     err_addr++;
            if (m_axi_awlen != v.exp_awlen) err_len++;
            aw_seen++;
         end
         if (m_axi_wvalid && !aw_hs) err_early++;
         if (m_axi_awvalid && m_axi_awready) aw_hs = 1;
         if (wr_fifo_empty && m_axi_wvalid) err_gap++;
         if (wr_fifo_re != (m_axi_wvalid && m_axi_wready)) err_re++;
         if (gap_cnt > 0) gap_cnt--;
         if (m_axi_wvalid && m_axi_wready) begin
            if (exp_q.size() == 0) err_data++;
            else if (m_axi_wdata != exp_q.pop_front()) err_data++;
            if (m_axi_wlast != (beat_idx == v.exp_beats - 1)) err_last++;
            fifo_q.delete(0);
            beat_idx++;
            if (beat_idx == v.gap_after) gap_cnt = v.gap_len;
            if (abort_after > 0 && beat_idx == abort_after) return;
         end
         if (m_axi_bready) begin
            b_seen++;
            if (m_axi_bvalid) b_hs = 1;
         end
         if (wr_done) begin
            done_cnt++;
            if (wr_resp != v.bresp) err_resp++;
         end
         if (wr_ready) begin
            ready_cyc = cyc;
            finished  = 1;
         end
      end

      check("burst_completes",   finished, 1);
      check("awvalid_next_cyc",  aw_first, 1);
      check("awaddr_stable",     err_addr, 0);
      check("awlen_stable",      err_len,  0);
      check("awvalid_hold_cyc",  aw_seen,  v.aw_delay + 1);
      check("no_w_before_aw",    err_early, 0);
      check("wvalid_in_gap",     err_gap,  0);
      check("fifo_re_match",     err_re,   0);
      check("wdata_order",       err_data, 0);
      check("wlast_position",    err_last, 0);
      check("beat_count",        beat_idx, v.exp_beats);
      check("bready_hold_cyc",   b_seen,   v.b_delay + 1);
      check("wr_done_once",      done_cnt, 1);
      check("wr_resp_at_done",   err_resp, 0);
      check("wr_resp_held",      wr_resp,  v.bresp);
      check("turnaround_cyc",    ready_cyc, 4 + v.exp_beats + v.aw_delay + v.b_delay + v.gap_len);
      check("awid_const",        m_axi_awid,    4'b1111);
      check("awcache_awsize",    {m_axi_awcache, m_axi_awsize, m_axi_awburst}, {4'b0011, 3'b011, 2'b01});
   endtask

   initial begin
      vec_t rv;

      //          len    addr           awd gapA gapL bd  bresp stray awlen beats
      vecs[0] = '{8'd1,  29'h000_0100,  0,  0,   0,   0,  2'b00, 0, 8'd0,   1};
      vecs[1] = '{8'd4,  29'h000_2000,  0,  1,   2,   0,  2'b00, 0, 8'd3,   4};
      vecs[2] = '{8'd3,  29'h1AB_CDE0,  5,  0,   0,   0,  2'b00, 1, 8'd2,   3};
      vecs[3] = '{8'd0,  29'h0FF_FF00,  0,  0,   0,   0,  2'b00, 0, 8'd255, 256};
      vecs[4] = '{8'd2,  29'h000_0040,  0,  0,   0,   3,  2'b10, 0, 8'd1,   2};
      vecs[5] = '{8'd8,  29'h1FF_FFC0,  2,  5,   1,   1,  2'b01, 0, 8'd7,   8};

      ARESETN       = 1'b0;
      wr_start      = 1'b0;
      wr_burst_len  = '0;
      wr_start_addr = '0;
      wr_fifo_data  = '0;
      wr_fifo_empty = 1'b1;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bid     = 4'b1111;
      m_axi_bresp   = 2'b00;
      m_axi_bvalid  = 1'b0;

      repeat (2) @(negedge ACLK);
      check_reset_outputs("por");
      ARESETN = 1'b1;

      for (int i = 0; i < 6; i++) run_burst(vecs[i], 0);

      // Mid-burst reset: two of four beats accepted, then reset for two cycles.
      rv = '{8'd4, 29'h000_3000, 0, 0, 0, 0, 2'b00, 0, 8'd3, 4};
      run_burst(rv, 2);
      @(negedge ACLK);
      ARESETN = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge ACLK);
      #1;
      check("midrst_no_done", wr_done, 0);
      check("midrst_idle", wr_ready, 1);
      ARESETN = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      wr_fifo_empty = 1'b1;

      rv = '{8'd2, 29'h000_0800, 0, 0, 0, 0, 2'b00, 0, 8'd1, 2};
      run_burst(rv, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ddr_axi_write.md
# ddr_axi_write

AXI4 write master for the DDR path: takes a burst request (start address, beat count) from the UI side, pulls data beats from a first-word-fall-through UI write FIFO, and issues one AXI4 INCR write burst (AW, W, B channels) to the memory controller. It is the write-direction counterpart of `ddr_axi_read` and shares its UI conventions, AXI constants and single-outstanding-burst model.

## Interface
- DATA_WIDTH, 64, AXI/FIFO data width (8 bytes per beat)
- ADDR_WIDTH, 29, AXI byte address width
- BURST_LEN_WIDTH, 8, burst length / AWLEN width
- ACLK  in  1  clock
- ARESETN  in  1  reset; asynchronous, active-low
- wr_start  in  1  request pulse; sampled only when wr_ready=1
- wr_burst_len  in  BURST_LEN_WIDTH  beats in burst; 0 means 256
- wr_start_addr  in  ADDR_WIDTH  burst start byte address
- wr_ready  out  1  idle, request accepted next wr_start
- wr_fifo_data  in  DATA_WIDTH  FWFT FIFO head word
- wr_fifo_empty  in  1  FIFO head invalid
- wr_fifo_re  out  1  pop FIFO head
- wr_done  out  1  one-cycle pulse, burst complete
- wr_resp  out  2  BRESP of last completed burst
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  4/ADDR_WIDTH/BURST_LEN_WIDTH/3/2/1/4/3/4  AW channel
- m_axi_awvalid  out  1; m_axi_awready  in  1
- m_axi_wdata  out  DATA_WIDTH; m_axi_wstrb  out  DATA_WIDTH/8; m_axi_wlast  out  1; m_axi_wvalid  out  1; m_axi_wready  in  1
- m_axi_bid  in  4; m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1

## Operation
- Constants: awid=4'b1111, awsize=3'b011, awburst=2'b01 (INCR), awlock=0, awcache=4'b0011, awprot=0, awqos=0, wstrb all ones.
- States: IDLE, AW, W, B, DONE.
- IDLE: wr_ready=1. On wr_start: register awaddr<=wr_start_addr, awlen<=wr_burst_len-1 (mod 2^BURST_LEN_WIDTH, so 0 gives 255), awvalid<=1, beat counter<=0, go AW.
- AW: hold awvalid, awaddr, awlen stable until awready; on awvalid&awready: awvalid<=0, go W. No W beat is driven before the AW handshake.
- W: wvalid = !wr_fifo_empty; wdata = wr_fifo_data; wr_fifo_re = wvalid & wready; wlast = (counter == awlen). Counter increments per accepted beat. On accepted beat with wlast: bready<=1, go B.
- B: hold bready until bvalid; on bvalid&bready: wr_resp<=bresp, bready<=0, go DONE. bid is not checked.
- DONE: wr_done=1 for exactly one cycle, then IDLE.
- wr_start outside IDLE is ignored. wvalid, wlast, wr_fifo_re are 0 outside W.
- Counter width BURST_LEN_WIDTH; it never wraps within a burst (max value = awlen).

## Timing
- Reset values: awvalid=0, awaddr=0, awlen=0, wvalid=0, wlast=0, wr_fifo_re=0, bready=0, wr_done=0, wr_resp=0, wr_ready=1, state IDLE.
- Reset asserted mid-burst: all of the above immediately; the partially written burst is abandoned and no wr_done is issued.
- wr_start at edge N → awvalid=1 from cycle N+1.
- AW handshake at edge k → awvalid=0 and first possible W beat in cycle k+1.
- Last W beat at edge m → bready=1 in cycle m+1.
- B handshake at edge j → wr_done=1 and wr_resp valid in cycle j+1; wr_ready=1 in cycle j+2.
- Minimum burst turnaround, all slaves ready: 4 + beats cycles from wr_start to wr_ready.
- W path is combinational from wr_fifo_empty/wr_fifo_data/wready; AW and B outputs are registered.

## Structure
- Shared package `ddr_axi_pkg` holds the AXI constants (ID, SIZE, BURST, LOCK, CACHE, PROT, QOS) used by both `ddr_axi_read` and this block; read and write use the same values.
- State encoding stays local to this block.
- No sub-module; the beat counter is inline.

## Test plan
- Single beat: len=1, addr=0x100, all slaves always ready → awaddr=0x100, awlen=0, one beat with wlast=1, one pop, wr_done pulse, wr_resp=2'b00.
- 4-beat burst, FIFO empty for 2 cycles after beat 1 → wvalid=0 during the gap, exactly 4 pops, wlast only on the 4th accepted beat, data order preserved.
- awready delayed 5 cycles → awvalid held and awaddr/awlen stable throughout; wvalid=0 until after the AW handshake.
- len=0 → awlen=255; 256 beats; wlast on beat 256 only; wr_done once.
- bvalid delayed 3 cycles with bresp=2'b10 → bready held high; wr_resp=2'b10 after wr_done; wr_ready returns to 1.
- ARESETN low after 2 of 4 beats → outputs at reset values; no wr_done; a following wr_start with len=2 completes normally.
